// File: rtl/gate_tt_checker.sv
// gate_tt_checker: drives the four input pairs onto a 2-input gate and checks its output against a truth table
module gate_tt_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    input  logic       y_dut,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK} state_t;
    state_t     state;
    logic [3:0] exp_q;
    logic [3:0] cnt;
    logic [1:0] idx;
    assign pass = done && fail_mask == 4'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            exp_q     <= '0;
            cnt       <= '0;
            idx       <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail_mask <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    exp_q          <= expected;
                    idx            <= '0;
                    cnt            <= '0;
                    fail_mask      <= '0;
                    done           <= 1'b0;
                    busy           <= 1'b1;
                    {a_out, b_out} <= 2'b00;
                    state          <= S_SETTLE;
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(SETTLE - 1)) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (y_dut != exp_q[idx]) fail_mask[idx] <= 1'b1;
                    if (idx != 2'd3) begin
                        idx            <= idx + 2'd1;
                        {a_out, b_out} <= idx + 2'd1;
                        cnt            <= '0;
                        state          <= S_SETTLE;
                    end else begin
                        {a_out, b_out} <= 2'b00;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: table-driven runs of SETTLE=2 and SETTLE=1 checkers against modelled gates
module tb_gate_tt_checker;
    logic       clk = 1'b0, rst = 1'b0, start1 = 1'b0, start2 = 1'b0, which = 1'b0;
    logic [3:0] exp_in = '0;
    logic [1:0] gsel = '0;
    logic       y1, y2, a1, b1, busy1, done1, pass1, a2, b2, busy2, done2, pass2;
    logic [3:0] fm1, fm2;
    logic       a_m, b_m, busy_m, done_m, pass_m;
    logic [3:0] fm_m;
    int checks = 0, errors = 0;

    typedef struct {
        logic [1:0] g;
        logic [3:0] e;
        logic [3:0] m;
        int         pulse;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    gate_tt_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .expected(exp_in), .y_dut(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1));
    gate_tt_checker #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .start(start2), .expected(exp_in), .y_dut(y2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fm2));

    // gate under test: 0=AND 1=OR 2=XOR 3=NAND
    function automatic logic gate(input logic [1:0] s, input logic a, input logic b);
        return s == 2'd0 ? (a & b) : s == 2'd1 ? (a | b) : s == 2'd2 ? (a ^ b) : ~(a & b);
    endfunction
    assign y1 = gate(gsel, a1, b1);
    assign y2 = gate(gsel, a2, b2);
    assign a_m    = which ? a1 : a2;
    assign b_m    = which ? b1 : b2;
    assign busy_m = which ? busy1 : busy2;
    assign done_m = which ? done1 : done2;
    assign pass_m = which ? pass1 : pass2;
    assign fm_m   = which ? fm1 : fm2;

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, " dut1"}, {a1, b1, busy1, done1, pass1, fm1}, '0);
        chk({n, " dut2"}, {a2, b2, busy2, done2, pass2, fm2}, '0);
    endtask

    // starts a run and checks every edge; stop>0 returns right after that edge
    task automatic run(input logic w, input logic [1:0] g, input logic [3:0] e, input logic [3:0] m,
                       input int pulse, input int stop);
        int s = w ? 1 : 2;
        int len = 4 * (s + 1);
        which = w;
        gsel  = g;
        @(negedge clk);
        exp_in = e;
        if (w) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        exp_in = ~e;
        chk("accept busy", busy_m, 1);
        chk("accept done", done_m, 0);
        chk("accept ab", {a_m, b_m}, 0);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == pulse) begin
                if (w) start1 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start2 = 1'b0;
            if (k < len) begin
                chk($sformatf("edge%0d ab", k), {a_m, b_m}, 9'(k / (s + 1)));
                chk($sformatf("edge%0d busy/done", k), {busy_m, done_m}, 9'b10);
            end else begin
                chk("end ab", {a_m, b_m}, 0);
                chk("end busy/done", {busy_m, done_m}, 9'b01);
                chk("end mask", fm_m, 9'(m));
                chk("end pass", pass_m, 9'(m == 4'b0));
            end
            if (k == stop) return;
        end
    endtask

    initial begin
        tbl[0] = '{2'd0, 4'b1000, 4'b0000, 0};
        tbl[1] = '{2'd1, 4'b1000, 4'b0110, 5};
        tbl[2] = '{2'd1, 4'b1110, 4'b0000, 0};
        tbl[3] = '{2'd2, 4'b0110, 4'b0000, 0};
        tbl[4] = '{2'd3, 4'b0111, 4'b0000, 0};
        tbl[5] = '{2'd0, 4'b0111, 4'b1111, 0};
        tbl[6] = '{2'd2, 4'b1000, 4'b1110, 0};

        #12 rst = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("idle after reset");

        foreach (tbl[i]) run(1'b0, tbl[i].g, tbl[i].e, tbl[i].m, tbl[i].pulse, 0);

        run(1'b0, 2'd1, 4'b1000, 4'b0000, 0, 7);
        chk("pre-reset mask", fm2, 9'b0010);
        #2 rst = 1'b1;
        #1 chk_zero("mid-run reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk_zero("after mid-run reset");
        run(1'b0, 2'd0, 4'b1000, 4'b0000, 0, 0);

        run(1'b1, 2'd2, 4'b0110, 4'b0000, 0, 0);
        run(1'b1, 2'd2, 4'b1000, 4'b1110, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
